// File: rtl/kianv_bus_pkg.sv
// kianv_bus_pkg: shared definitions for the scratch-SRAM bus responder.
//   - FSM state encoding (IDLE=0, WAIT=1, ACCESS=2, RESP=3)
//   - bus widths, wait counter width, range-error read pattern
//   - read-data source select used by the responder's output mux
package kianv_bus_pkg;

  localparam int DATA_W     = 32;
  localparam int STRB_W     = 4;
  localparam int WAIT_CNT_W = 4;

  localparam logic [DATA_W-1:0] ERR_PATTERN = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Where mem_rdata currently comes from. ZERO covers the post-reset value
  // before any read has completed.
  typedef enum logic [1:0] {
    RSEL_ZERO = 2'd0,
    RSEL_SRAM = 2'd1,
    RSEL_ERR  = 2'd2
  } rsel_e;

endpackage

// File: rtl/sram_bytewrite.sv
// sram_bytewrite: synchronous single-port word array, byte-lane write
// enables, registered read. Written in the usual block-RAM template.
// Ports:
//   clk    clock
//   en     access enable (read when we==0, write otherwise)
//   we     per-byte write enables
//   addr   word index
//   wdata  write data
//   rdata  registered read data; only updates on an enabled read
module sram_bytewrite
  import kianv_bus_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we == '0) rdata_q <= mem[addr];
      for (int b = 0; b < STRB_W; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_sram_responder.sv
// bus_sram_responder: target end of the core's valid/ready memory bus,
// served from an internal scratch SRAM with a fixed wait-state latency.
// A request sampled in IDLE gets mem_ready exactly WAIT_STATES+2 cycles later.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   mem_valid/addr/wdata/wstrb  request (wstrb==0 is a read)
//   mem_ready              one-cycle response pulse
//   mem_rdata              read data, held until the next read completes
//   mem_err                range error, alongside mem_ready
// Build option: define BUS_RANGE_CHECK_EN to flag out-of-window accesses
// (write dropped, rdata=ERR_PATTERN, mem_err=1). Without it addresses alias
// modulo the array size and mem_err is tied low.
module bus_sram_responder
  import kianv_bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WS = WAIT_CNT_W'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                ready_q, ready_d;
  rsel_e               rsel_q, rsel_d;

  logic [31:0]         off;
  logic [IDX_W-1:0]    idx;
  logic                oor;
  logic [DATA_W-1:0]   sram_rdata;
  logic                sram_en;

  // Offset within the window; truncation of the index gives the aliasing.
  assign off = addr_q - BASE_ADDR;
  assign idx = off[IDX_W+1:2];

`ifdef BUS_RANGE_CHECK_EN
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  assign oor = (off >= SPAN);
`else
  assign oor = 1'b0;
`endif

  logic unused_off;
  assign unused_off = ^{off[1:0], off[31:IDX_W+2]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rsel_d  = rsel_q;
    ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          cnt_d   = WS;
          state_d = (WS != '0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // ready is registered here so it shows up during RESP
        ready_d = 1'b1;
        state_d = ST_RESP;
        if (oor)                rsel_d = RSEL_ERR;
        else if (wstrb_q == '0) rsel_d = RSEL_SRAM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      rsel_q  <= RSEL_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      rsel_q  <= rsel_d;
    end
  end

  // Gating with resetn drops a write whose ACCESS cycle coincides with reset.
  assign sram_en = (state_q == ST_ACCESS) && !oor && resetn;

  sram_bytewrite #(.DEPTH(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (wstrb_q),
    .addr  (idx),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  always_comb begin
    case (rsel_q)
      RSEL_SRAM: mem_rdata = sram_rdata;
      RSEL_ERR:  mem_rdata = ERR_PATTERN;
      default:   mem_rdata = '0;
    endcase
  end

  assign mem_ready = ready_q;

`ifdef BUS_RANGE_CHECK_EN
  logic err_q, err_d;
  assign err_d = (state_q == ST_ACCESS) && oor;
  always_ff @(posedge clk) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_sram_responder.sv
module tb_bus_sram_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WS0   = 2;
  localparam int          WS1   = 0;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  always #5 clk = ~clk;

  bus_sram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS0)) u0 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_ready(ready[0]),
    .mem_rdata(rdata[0]), .mem_err(err[0]));

  bus_sram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS1)) u1 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_ready(ready[1]),
    .mem_rdata(rdata[1]), .mem_err(err[1]));

  int nvec = 0;
  int nerr = 0;
  int rdy_cnt [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) if (ready[k] === 1'b1) rdy_cnt[k] <= rdy_cnt[k] + 1;
  end

  // Reference model: plain word array per instance plus last read value.
  logic [31:0] mdl [2][DEPTH];
  logic [31:0] last_rd [2];

  function automatic void mdl_apply(input int i, input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] s, output logic [31:0] er, output logic ee);
    logic [31:0] o;
    int w;
    o  = a - BASE;
    w  = int'((o >> 2) % DEPTH);
    ee = 1'b0;
`ifdef BUS_RANGE_CHECK_EN
    if (o >= DEPTH * 4) begin
      ee = 1'b1;
      last_rd[i] = 32'hDEAD_BEEF;
      er = last_rd[i];
      return;
    end
`endif
    if (s == 4'h0) last_rd[i] = mdl[i][w];
    else for (int b = 0; b < 4; b++) if (s[b]) mdl[i][w][8*b +: 8] = d[8*b +: 8];
    er = last_rd[i];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called #1 after a posedge with the DUT in IDLE; returns in the next IDLE.
  task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic e, output int lat);
    addr[i] = a; wdata[i] = d; wstrb[i] = s; valid[i] = 1'b1;
    lat = 0; rd = '0; e = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (ready[i] === 1'b1) begin rd = rdata[i]; e = err[i]; break; end
      if (lat > 40) begin lat = -1; break; end
    end
    valid[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic txn(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic e);
    logic [31:0] er;
    logic ee;
    int lat;
    do_req(i, a, d, s, rd, e, lat);
    mdl_apply(i, a, d, s, er, ee);
    check($sformatf("lat%0d", i), 32'(lat), 32'((i == 0 ? WS0 : WS1) + 2));
    check($sformatf("rdata%0d@%h", i, a), rd, er);
    check($sformatf("err%0d@%h", i, a), {31'b0, e}, {31'b0, ee});
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        chk;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [31:0] rd;
    logic e;
    int n, lat;
    logic [31:0] ba [3];

    for (int k = 0; k < 2; k++) begin
      valid[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
      last_rd[k] = '0; rdy_cnt[k] = 0;
    end

    tbl[0] = '{32'h10,   32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{32'h10,   32'h0,         4'h0, 1'b1, 32'h1234_5678, 1'b0};
    tbl[2] = '{32'h40,   32'hAABB_CCDD, 4'hF, 1'b0, 32'h0, 1'b0};
    tbl[3] = '{32'h40,   32'h1122_3344, 4'h5, 1'b0, 32'h0, 1'b0};
    tbl[4] = '{32'h40,   32'h0,         4'h0, 1'b1, 32'hAA22_CC44, 1'b0};
    tbl[5] = '{32'h0,    32'h0BAD_F00D, 4'hF, 1'b0, 32'h0, 1'b0};
`ifdef BUS_RANGE_CHECK_EN
    tbl[6] = '{32'h1000, 32'hCAFE_0001, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b1};
    tbl[7] = '{32'h0,    32'h0,         4'h0, 1'b1, 32'h0BAD_F00D, 1'b0};
`else
    tbl[6] = '{32'h1000, 32'hCAFE_0001, 4'hF, 1'b0, 32'h0, 1'b0};
    tbl[7] = '{32'h0,    32'h0,         4'h0, 1'b1, 32'hCAFE_0001, 1'b0};
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_ready%0d", k), {31'b0, ready[k]}, 32'h0);
      check($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
      check($sformatf("rst_err%0d", k), {31'b0, err[k]}, 32'h0);
    end
    resetn = 1'b1;
    @(posedge clk); #1;

    // directed table on the WAIT_STATES=2 instance
    for (int v = 0; v < 8; v++) begin
      txn(0, tbl[v].a, tbl[v].d, tbl[v].s, rd, e);
      if (tbl[v].chk) check($sformatf("tbl%0d_rdata", v), rd, tbl[v].er);
      check($sformatf("tbl%0d_err", v), {31'b0, e}, {31'b0, tbl[v].ee});
    end

    // back-to-back reads, WAIT_STATES=0, valid held continuously
    txn(1, 32'h100, 32'h1111_0000, 4'hF, rd, e);
    txn(1, 32'h104, 32'h2222_0000, 4'hF, rd, e);
    txn(1, 32'h108, 32'h3333_0000, 4'hF, rd, e);
    ba[0] = 32'h100; ba[1] = 32'h104; ba[2] = 32'h108;
    begin
      int base_cnt, req;
      logic [31:0] er;
      logic ee;
      base_cnt = rdy_cnt[1];
      req = 0;
      addr[1] = ba[0]; wstrb[1] = 4'h0; valid[1] = 1'b1;
      for (n = 1; n <= 9; n++) begin
        @(posedge clk); #1;
        check($sformatf("b2b_ready_c%0d", n), {31'b0, ready[1]}, {31'b0, (n % 3) == 2});
        if (ready[1] === 1'b1 && req < 3) begin
          mdl_apply(1, ba[req], 32'h0, 4'h0, er, ee);
          check($sformatf("b2b_rdata%0d", req), rdata[1], er);
          req++;
          if (req < 3) addr[1] = ba[req];
          else valid[1] = 1'b0;
        end
      end
      check("b2b_ready_count", 32'(rdy_cnt[1] - base_cnt), 32'd3);
    end

    // reset during WAIT aborts the write
    txn(0, 32'h20, 32'h0F0F_55AA, 4'hF, rd, e);
    begin
      int base_cnt;
      addr[0] = 32'h20; wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 4'hF; valid[0] = 1'b1;
      @(posedge clk); #1;
      resetn = 1'b0; valid[0] = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      check("rst_mid_rdata0", rdata[0], 32'h0);
      check("rst_mid_rdata1", rdata[1], 32'h0);
      last_rd[0] = '0; last_rd[1] = '0;
      base_cnt = rdy_cnt[0];
      repeat (6) @(posedge clk);
      #1;
      check("rst_mid_no_ready", 32'(rdy_cnt[0] - base_cnt), 32'd0);
    end
    txn(0, 32'h20, 32'h0, 4'h0, rd, e);
    check("rst_mid_prior", rd, 32'h0F0F_55AA);

    // request inputs change during WAIT; latched values must win
    txn(0, 32'h34, 32'h2468_ACE0, 4'hF, rd, e);
    begin
      logic [31:0] er;
      logic ee;
      addr[0] = 32'h30; wdata[0] = 32'h1357_9BDF; wstrb[0] = 4'hF; valid[0] = 1'b1;
      @(posedge clk); #1;
      addr[0] = 32'h34; wdata[0] = 32'hFFFF_0000; wstrb[0] = 4'h0;
      lat = 1;
      while (ready[0] !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      check("stab_lat", 32'(lat), 32'(WS0 + 2));
      valid[0] = 1'b0;
      @(posedge clk); #1;
      mdl_apply(0, 32'h30, 32'h1357_9BDF, 4'hF, er, ee);
    end
    txn(0, 32'h30, 32'h0, 4'h0, rd, e);
    check("stab_word30", rd, 32'h1357_9BDF);
    txn(0, 32'h34, 32'h0, 4'h0, rd, e);
    check("stab_word34", rd, 32'h2468_ACE0);

    // randomized traffic against the model
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++) txn(i, BASE + 32'(w * 4), $urandom, 4'hF, rd, e);
    for (int t = 0; t < 200; t++) begin
      int i;
      logic [31:0] a;
      logic [3:0] s;
      i = int'($urandom % 2);
      a = BASE + 32'(($urandom % 16) * 4) + 32'($urandom % 4);
      if ($urandom % 8 == 0) a = a + 32'h1000 * 32'($urandom_range(1, 3));
      s = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom % 16);
      txn(i, a, $urandom, s, rd, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
